// File: rtl/gb_bus_pkg.sv
// Shared bus definitions for the Game Boy style system bus.
// Holds the DMA register address, sprite table location and length,
// the echo-RAM page boundary, the DMA state encoding and the helper
// that maps a source page/index pair onto a bus address.
package gb_bus_pkg;

  localparam logic [15:0] REG_DMA   = 16'hff46;
  localparam logic [15:0] OAM_BASE  = 16'hfe00;
  localparam int          OAM_LEN   = 160;
  localparam logic [7:0]  ECHO_PAGE = 8'he0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } dma_state_t;

  // Pages at or above the echo boundary alias work RAM 0x2000 lower.
  function automatic logic [15:0] dma_src_addr(input logic [7:0] page,
                                               input logic [7:0] idx);
    logic [15:0] addr;
    if (page >= ECHO_PAGE) begin
      addr = {page - 8'h20, idx};
    end else begin
      addr = {page, idx};
    end
    return addr;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA initiator.
// Writing a page number to the DMA register copies LENGTH bytes from
// {page,00}.. into the sprite table at DST_BASE, one byte per
// READ / WAIT(READ_LATENCY) / WRITE sequence.
// Ports:
//   clockgb, resetn          clock and asynchronous active-low reset
//   address/indata/load/store CPU slave port (register at REG_ADDR)
//   outdata                  CPU read data, 0 when not addressed
//   dma_address/dma_outdata  initiator address and write data
//   dma_indata               initiator read data
//   dma_load/dma_store       one-cycle initiator strobes
//   dma_active               transfer in progress (bus granted to DMA)
// All outputs are registered; they are computed from the next state so
// the strobes line up with the state they belong to.
module oam_dma
  import gb_bus_pkg::*;
#(
  parameter logic [15:0] REG_ADDR     = REG_DMA,
  parameter logic [15:0] DST_BASE     = OAM_BASE,
  parameter int          LENGTH       = OAM_LEN,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clockgb,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  output logic [15:0] dma_address,
  output logic [7:0]  dma_outdata,
  input  logic [7:0]  dma_indata,
  output logic        dma_load,
  output logic        dma_store,
  output logic        dma_active
);

  localparam int             WW        = $clog2(READ_LATENCY + 1);
  localparam logic [WW-1:0]  WAIT_LOAD = WW'(READ_LATENCY - 1);
  localparam logic [WW-1:0]  WAIT_ONE  = WW'(1);
  localparam logic [7:0]     LAST      = 8'(LENGTH - 1);

  dma_state_t    state_r, state_n;
  logic [7:0]    page_r, page_n;
  logic [7:0]    count_r, count_n;
  logic [WW-1:0] wait_r, wait_n;
  logic          latch_s;
  logic          cpu_wr_s;
  logic          cpu_rd_s;
  logic [15:0]   addr_n;

  assign cpu_wr_s = store && (address == REG_ADDR);
  assign cpu_rd_s = load && (address == REG_ADDR);

  // Next-state logic; a CPU write always restarts at byte 0. When it
  // coincides with a WRITE cycle that store is already on the bus, so
  // the final byte completes before the new transfer begins.
  always_comb begin
    state_n = state_r;
    page_n  = page_r;
    count_n = count_r;
    wait_n  = wait_r;
    latch_s = 1'b0;
    if (cpu_wr_s) begin
      page_n  = indata;
      count_n = 8'h00;
      state_n = READ;
    end else begin
      case (state_r)
        IDLE: begin
          state_n = IDLE;
        end
        READ: begin
          state_n = WAIT;
          wait_n  = WAIT_LOAD;
        end
        WAIT: begin
          if (wait_r == '0) begin
            latch_s = 1'b1;
            state_n = WRITE;
          end else begin
            wait_n = wait_r - WAIT_ONE;
          end
        end
        WRITE: begin
          if (count_r == LAST) begin
            state_n = IDLE;
          end else begin
            count_n = count_r + 8'd1;
            state_n = READ;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Address for the upcoming cycle; held while idle or waiting.
  always_comb begin
    addr_n = dma_address;
    if (state_n == READ) begin
      addr_n = dma_src_addr(page_n, count_n);
    end else if (state_n == WRITE) begin
      addr_n = DST_BASE + {8'h00, count_n};
    end else begin
      addr_n = dma_address;
    end
  end

  // State, transfer registers and registered outputs.
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      page_r      <= 8'h00;
      count_r     <= 8'h00;
      wait_r      <= '0;
      outdata     <= 8'h00;
      dma_address <= 16'h0000;
      dma_outdata <= 8'h00;
      dma_load    <= 1'b0;
      dma_store   <= 1'b0;
      dma_active  <= 1'b0;
    end else begin
      state_r     <= state_n;
      page_r      <= page_n;
      count_r     <= count_n;
      wait_r      <= wait_n;
      outdata     <= cpu_rd_s ? page_r : 8'h00;
      dma_address <= addr_n;
      if (latch_s) begin
        dma_outdata <= dma_indata;
      end
      dma_load    <= (state_n == READ);
      dma_store   <= (state_n == WRITE);
      dma_active  <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma.
module tb_oam_dma;

  logic        clockgb = 1'b0;
  logic        resetn  = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  indata  = 8'h00;
  logic [7:0]  outdata;
  logic        load    = 1'b0;
  logic        store   = 1'b0;
  logic [15:0] dma_address;
  logic [7:0]  dma_outdata;
  logic [7:0]  dma_indata;
  logic        dma_load;
  logic        dma_store;
  logic        dma_active;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  rd_data = 8'h00;
  logic [7:0]  oam [0:159];
  logic        clr = 1'b0;
  int          n_loads = 0, n_stores = 0, n_active = 0, n_overlap = 0;
  logic [15:0] first_load = 16'h0, last_load = 16'h0, last_store = 16'h0;

  always #5 clockgb = ~clockgb;

  oam_dma dut (
    .clockgb     (clockgb),
    .resetn      (resetn),
    .address     (address),
    .indata      (indata),
    .outdata     (outdata),
    .load        (load),
    .store       (store),
    .dma_address (dma_address),
    .dma_outdata (dma_outdata),
    .dma_indata  (dma_indata),
    .dma_load    (dma_load),
    .dma_store   (dma_store),
    .dma_active  (dma_active)
  );

  assign dma_indata = rd_data;

  // Source memory contents, as a fixed pattern per page.
  function automatic logic [7:0] src_fn(input logic [15:0] a);
    case (a[15:8])
      8'hc0:   return a[7:0] ^ 8'h5a;
      8'hc1:   return ~a[7:0];
      8'hd0:   return a[7:0] + 8'h33;
      default: return 8'h00;
    endcase
  endfunction

  // Bus model: one-cycle read latency, sprite table store, statistics.
  always @(posedge clockgb) begin
    if (dma_load) rd_data <= src_fn(dma_address);
    if (dma_store && dma_address >= 16'hfe00 && dma_address < 16'hfea0)
      oam[dma_address[7:0]] <= dma_outdata;
    if (clr) begin
      n_loads <= 0; n_stores <= 0; n_active <= 0; n_overlap <= 0;
    end else begin
      if (dma_active) n_active <= n_active + 1;
      if (dma_load) begin
        if (n_loads == 0) first_load <= dma_address;
        last_load <= dma_address;
        n_loads   <= n_loads + 1;
      end
      if (dma_store) begin
        last_store <= dma_address;
        n_stores   <= n_stores + 1;
      end
      if (dma_load && dma_store) n_overlap <= n_overlap + 1;
    end
  end

  task automatic clear_stats;
    clr = 1'b1;
    @(negedge clockgb);
    clr = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the following cycle.
  task automatic cpu_write(input logic [7:0] page);
    store = 1'b1; address = 16'hff46; indata = page;
    @(negedge clockgb);
    store = 1'b0; address = 16'h0000; indata = 8'h00;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (dma_active && k < budget) begin
      @(negedge clockgb);
      k++;
    end
    n_cmp++;
    if (dma_active !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_idle_timeout: dma_active=%b required 0", tag, dma_active);
    end
  endtask

  task automatic wait_stores(input int n, input int budget, input string tag);
    int k = 0;
    while (n_stores < n && k < budget) begin
      @(negedge clockgb);
      k++;
    end
    n_cmp++;
    if (n_stores < n) begin
      n_bad++;
      $display("FAIL %s_store_timeout: stores=%0d required %0d", tag, n_stores, n);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clockgb);
    n_cmp++;
    if ({outdata, dma_address, dma_outdata, dma_load, dma_store, dma_active} !== 35'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: out=%h addr=%h wd=%h ld=%b st=%b act=%b required all 0",
               outdata, dma_address, dma_outdata, dma_load, dma_store, dma_active);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clockgb);
    n_cmp++;
    if (dma_active !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: dma_active=%b required 0", dma_active);
    end
  endtask

  task automatic test_register_read;
    cpu_write(8'h3c);
    load = 1'b1; address = 16'hff46;
    @(negedge clockgb);
    n_cmp++;
    if (outdata !== 8'h3c) begin
      n_bad++;
      $display("FAIL regread_ff46: outdata=%h required 3c", outdata);
    end
    address = 16'hff45;
    @(negedge clockgb);
    n_cmp++;
    if (outdata !== 8'h00) begin
      n_bad++;
      $display("FAIL regread_ff45: outdata=%h required 00", outdata);
    end
    load = 1'b0; address = 16'h0000;
    wait_idle(600, "regread");
  endtask

  task automatic test_page_copy;
    clear_stats();
    cpu_write(8'hc0);
    // cycle 1: READ
    n_cmp++;
    if ({dma_active, dma_load, dma_store, dma_address} !== {3'b110, 16'hc000}) begin
      n_bad++;
      $display("FAIL cyc1_read: act=%b ld=%b st=%b addr=%h required 1 1 0 c000",
               dma_active, dma_load, dma_store, dma_address);
    end
    @(negedge clockgb); // cycle 2: WAIT
    n_cmp++;
    if ({dma_load, dma_store} !== 2'b00) begin
      n_bad++;
      $display("FAIL cyc2_wait: ld=%b st=%b required 0 0", dma_load, dma_store);
    end
    @(negedge clockgb); // cycle 3: WRITE
    n_cmp++;
    if ({dma_load, dma_store, dma_address, dma_outdata} !== {2'b01, 16'hfe00, 8'h5a}) begin
      n_bad++;
      $display("FAIL cyc3_write: ld=%b st=%b addr=%h wd=%h required 0 1 fe00 5a",
               dma_load, dma_store, dma_address, dma_outdata);
    end
    @(negedge clockgb); // cycle 4: next READ
    n_cmp++;
    if ({dma_load, dma_store, dma_address} !== {2'b10, 16'hc001}) begin
      n_bad++;
      $display("FAIL cyc4_read: ld=%b st=%b addr=%h required 1 0 c001",
               dma_load, dma_store, dma_address);
    end
    wait_idle(600, "copy");
    n_cmp++;
    if (n_active !== 480) begin
      n_bad++;
      $display("FAIL copy_active_cycles: got %0d required 480", n_active);
    end
    n_cmp++;
    if (n_stores !== 160 || n_loads !== 160) begin
      n_bad++;
      $display("FAIL copy_strobes: stores=%0d loads=%0d required 160 160", n_stores, n_loads);
    end
    n_cmp++;
    if (n_overlap !== 0) begin
      n_bad++;
      $display("FAIL copy_overlap: got %0d required 0", n_overlap);
    end
    for (int i = 0; i < 160; i++) begin
      n_cmp++;
      if (oam[i] !== (8'(i) ^ 8'h5a)) begin
        n_bad++;
        $display("FAIL copy_data[%0d]: got %h required %h", i, oam[i], 8'(i) ^ 8'h5a);
      end
    end
  endtask

  task automatic test_echo;
    clear_stats();
    cpu_write(8'he1);
    wait_idle(600, "echo");
    n_cmp++;
    if (first_load !== 16'hc100 || last_load !== 16'hc19f) begin
      n_bad++;
      $display("FAIL echo_src: first=%h last=%h required c100 c19f", first_load, last_load);
    end
    n_cmp++;
    if (last_store !== 16'hfe9f || n_stores !== 160) begin
      n_bad++;
      $display("FAIL echo_dst: last=%h stores=%0d required fe9f 160", last_store, n_stores);
    end
    n_cmp++;
    if (oam[0] !== 8'hff || oam[159] !== 8'h60) begin
      n_bad++;
      $display("FAIL echo_data: oam0=%h oam159=%h required ff 60", oam[0], oam[159]);
    end
  endtask

  task automatic test_restart;
    clear_stats();
    cpu_write(8'hc0);
    wait_stores(50, 400, "restart");
    cpu_write(8'hd0);
    n_cmp++;
    if ({dma_load, dma_store, dma_address} !== {2'b10, 16'hd000}) begin
      n_bad++;
      $display("FAIL restart_first: ld=%b st=%b addr=%h required 1 0 d000",
               dma_load, dma_store, dma_address);
    end
    wait_idle(600, "restart");
    n_cmp++;
    if (n_active !== 631) begin
      n_bad++;
      $display("FAIL restart_active_cycles: got %0d required 631", n_active);
    end
    n_cmp++;
    if (n_stores !== 210) begin
      n_bad++;
      $display("FAIL restart_stores: got %0d required 210", n_stores);
    end
    for (int i = 0; i < 160; i++) begin
      n_cmp++;
      if (oam[i] !== (8'(i) + 8'h33)) begin
        n_bad++;
        $display("FAIL restart_data[%0d]: got %h required %h", i, oam[i], 8'(i) + 8'h33);
      end
    end
  endtask

  task automatic test_final_overlap;
    int k = 0;
    clear_stats();
    cpu_write(8'hc0);
    while (!(dma_store && dma_address == 16'hfe9f) && k < 600) begin
      @(negedge clockgb);
      k++;
    end
    n_cmp++;
    if (!(dma_store === 1'b1 && dma_address === 16'hfe9f)) begin
      n_bad++;
      $display("FAIL overlap_final_timeout: st=%b addr=%h required 1 fe9f", dma_store, dma_address);
    end
    cpu_write(8'hc1);
    n_cmp++;
    if (oam[159] !== 8'hc5) begin
      n_bad++;
      $display("FAIL overlap_final_store: oam159=%h required c5", oam[159]);
    end
    n_cmp++;
    if ({dma_active, dma_load, dma_address} !== {2'b11, 16'hc100}) begin
      n_bad++;
      $display("FAIL overlap_restart: act=%b ld=%b addr=%h required 1 1 c100",
               dma_active, dma_load, dma_address);
    end
    wait_idle(600, "overlap");
    n_cmp++;
    if (n_stores !== 320 || oam[0] !== 8'hff || oam[159] !== 8'h60) begin
      n_bad++;
      $display("FAIL overlap_second: stores=%0d oam0=%h oam159=%h required 320 ff 60",
               n_stores, oam[0], oam[159]);
    end
  endtask

  task automatic test_reset_mid;
    clear_stats();
    cpu_write(8'hc0);
    wait_stores(80, 400, "rstmid");
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({outdata, dma_address, dma_outdata, dma_load, dma_store, dma_active} !== 35'h0) begin
      n_bad++;
      $display("FAIL rstmid_async: out=%h addr=%h wd=%h ld=%b st=%b act=%b required all 0",
               outdata, dma_address, dma_outdata, dma_load, dma_store, dma_active);
    end
    @(negedge clockgb);
    resetn = 1'b1;
    clear_stats();
    repeat (20) @(negedge clockgb);
    n_cmp++;
    if (dma_active !== 1'b0 || n_loads !== 0 || n_active !== 0) begin
      n_bad++;
      $display("FAIL rstmid_stays_idle: act=%b loads=%0d active=%0d required 0 0 0",
               dma_active, n_loads, n_active);
    end
    cpu_write(8'hc0);
    n_cmp++;
    if ({dma_active, dma_load, dma_address} !== {2'b11, 16'hc000}) begin
      n_bad++;
      $display("FAIL rstmid_rearm: act=%b ld=%b addr=%h required 1 1 c000",
               dma_active, dma_load, dma_address);
    end
    wait_idle(600, "rstmid");
  endtask

  initial begin
    test_reset();
    test_register_read();
    test_page_copy();
    test_echo();
    test_restart();
    test_final_overlap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
